board_input_conditioner: RTL and testbench
==========================================

// Module: board_input_conditioner
// PURPOSE
//  Board-level front end for the datapath. Stretches the reset button into a clean reset
//  pulse of RST_CYCLES. Synchronises and debounces SW_W switch channels into a stable bus.
//  Flags each debounced change with a one-cycle edge pulse. Its outputs drive the
//  datapath's rst and sw inputs, replacing the bare count-decoded rst/sw stimulus.
// PARAMETERS
//  SW_W            3     switch channel count (>=1)
//  RST_CYCLES      16    extra cycles rst_out stays high after rst falls (>=1)
//  DEBOUNCE_CYCLES 1000  consecutive stable synced cycles required to accept a change (>=1)
//  SYNC_STAGES     2     synchroniser flops per channel (>=2)
// PORTS
//  clk       in   1     system clock; single clock domain
//  rst       in   1     reset, synchronous, active-high (raw button, already glitch-free)
//  sw_in     in   SW_W  raw asynchronous switch inputs
//  rst_out   out  1     stretched reset to datapath, active-high
//  ready     out  1     1 once rst_out has fallen; equals ~rst_out
//  sw_out    out  SW_W  debounced switch value
//  sw_edge   out  SW_W  1-cycle pulse per channel on the cycle sw_out[i] changes
// BEHAVIOUR
//  Reset (rst sampled 1):
//   - next edge: rst_out=1, ready=0, sw_out=0, sw_edge=0.
//   - Stretch counter, debounce counters and sync flops cleared.
//   - Applies at any time, including mid-stretch or mid-debounce.
//  Stretch:
//   - rst_out stays 1 for exactly RST_CYCLES edges after the last cycle rst is sampled 1.
//   - On the RST_CYCLES-th edge, rst_out->0 and ready->1 together.
//   - Re-asserting rst restarts the full stretch.
//  Sync chain: SYNC_STAGES flops per channel; runs whenever rst=0, including during stretch.
//  Debounce, per channel i, 2 states:
//   - IDLE: synced s == sw_out[i]; count=0.
//   - CHECK: s != sw_out[i]; count increments each cycle.
//   - In CHECK, s returning to sw_out[i] before the limit -> IDLE, count=0 (bounce rejected).
//   - count reaching DEBOUNCE_CYCLES consecutive mismatches -> on that edge, sw_out[i]<=s,
//     sw_edge[i]=1 for one cycle, count=0, state IDLE.
//   - While rst_out=1: all channels held in IDLE with count=0, sw_out=0, sw_edge=0.
//  Latency: steady sw_in change first sampled at edge t (ready=1) -> sw_out/sw_edge update
//   at edge t+SYNC_STAGES+DEBOUNCE_CYCLES-1.
//  Boundary rules:
//   - Counter width $clog2(DEBOUNCE_CYCLES+1); saturates at the limit, never wraps.
//   - Channels are independent; simultaneous changes yield a multi-bit sw_edge in the same cycle.
//   - A 1-cycle glitch never reaches sw_out when DEBOUNCE_CYCLES>1.
//   - sw_in held nonzero through the stretch: sw_out=0 until ready, then it updates
//     DEBOUNCE_CYCLES edges after ready rises.
//  All outputs registered; no combinational path from any input to any output.
// STRUCTURE
//  Shared header board_defs.vh:
//   - Debounce state encodings: DB_IDLE=1'b0, DB_CHECK=1'b1.
//   - Default SW_W and DEBOUNCE_CYCLES for the board build.
//  Sub-module sw_debounce_ch (sync chain + counter + state for one channel), SW_W copies
//   via a generate loop.
//  Top level holds the stretch counter plus rst_out/ready generation.
// TESTING  (SW_W=3, RST_CYCLES=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
//  1. rst=1 for 2 cycles, then 0 -> rst_out=1 for 4 more edges; ready=1 on 4th edge;
//     sw_out=000, sw_edge=000 throughout.
//  2. After ready, sw_in=101 steady from edge t -> sw_out=101 and sw_edge=101 at edge t+9;
//     sw_edge=000 at t+10.
//  3. sw_in[0]: 1 for 5 cycles, 0 for 1, then 1 steady -> no early change; sw_out[0]=1 eight
//     edges after the final synced rise; exactly one sw_edge[0] pulse.
//  4. Debounce at count 6 with rst pulsed for 1 cycle -> sw_out=000, rst_out=1, stretch
//     restarts (4 edges); no sw_edge pulse emitted.
//  5. sw_in=111 held through reset and stretch -> sw_out=000 while rst_out=1; sw_out=111 and
//     sw_edge=111 at 8th edge after ready.
//  6. Single-cycle 1 pulse on sw_in[2] with ready=1 -> sw_out and sw_edge unchanged.

Source files
------------

// File: rtl/board_input_conditioner_pkg.sv
// Shared types and board-build defaults for the board input conditioner.
package board_input_conditioner_pkg;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_CHECK = 1'b1
    } db_state_e;

    localparam int SW_W_DEF            = 3;
    localparam int RST_CYCLES_DEF      = 16;
    localparam int DEBOUNCE_CYCLES_DEF = 1000;
    localparam int SYNC_STAGES_DEF     = 2;

    // Width of a counter that must be able to represent 0..limit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/board_input_conditioner_sw_debounce_ch.sv
// One switch channel: synchroniser chain followed by a consecutive-mismatch debouncer.
module board_input_conditioner_sw_debounce_ch
    import board_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic sw_in,
    output logic sw_out,
    output logic sw_edge
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   edge_q, edge_d;

    logic                   synced;
    logic                   mismatch;
    logic [CW-1:0]          run;
    logic                   at_limit;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign mismatch = (synced != out_q);
    assign run      = (state_q == DB_CHECK) ? cnt_q : {CW{1'b0}};
    assign at_limit = (run >= LAST);

    // State register: sync chain, debounce state, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{1'b0}};
            state_q <= DB_IDLE;
            cnt_q   <= {CW{1'b0}};
            out_q   <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            edge_q  <= edge_d;
        end
    end

    // The synchroniser keeps running while the stretched reset holds the debouncer.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_in};
    end

    // Next-state logic: stay in CHECK only while a mismatch run is still short of the limit.
    always_comb begin
        state_d = DB_IDLE;
        if (hold) begin
            state_d = DB_IDLE;
        end else begin
            case (state_q)
                DB_IDLE: begin
                    if (mismatch && !at_limit) state_d = DB_CHECK;
                    else                       state_d = DB_IDLE;
                end
                DB_CHECK: begin
                    if (mismatch && !at_limit) state_d = DB_CHECK;
                    else                       state_d = DB_IDLE;
                end
                default: state_d = DB_IDLE;
            endcase
        end
    end

    // Output logic: count mismatches, accept the new level on the limiting edge.
    always_comb begin
        cnt_d  = {CW{1'b0}};
        out_d  = out_q;
        edge_d = 1'b0;
        if (hold) begin
            out_d = 1'b0;
        end else if (mismatch) begin
            if (at_limit) begin
                out_d  = synced;
                edge_d = 1'b1;
            end else begin
                cnt_d = run + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    assign sw_out  = out_q;
    assign sw_edge = edge_q;

endmodule

// File: rtl/board_input_conditioner.sv
// Board front end: stretched reset generation plus SW_W debounced switch channels.
module board_input_conditioner
    import board_input_conditioner_pkg::*;
#(
    parameter int SW_W            = SW_W_DEF,
    parameter int RST_CYCLES      = RST_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_in,
    output logic            rst_out,
    output logic            ready,
    output logic [SW_W-1:0] sw_out,
    output logic [SW_W-1:0] sw_edge
);

    localparam int             SCW  = cnt_width(RST_CYCLES);
    localparam logic [SCW-1:0] LAST = SCW'(RST_CYCLES - 1);

    logic [SCW-1:0] stretch_q, stretch_d;
    logic           rst_out_q, rst_out_d;
    logic           ready_q, ready_d;

    // Stretch register; any sampled rst restarts the full stretch.
    always_ff @(posedge clk) begin
        if (rst) begin
            stretch_q <= {SCW{1'b0}};
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            stretch_q <= stretch_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    // Count edges since rst dropped; release on the RST_CYCLES-th one.
    always_comb begin
        stretch_d = {SCW{1'b0}};
        rst_out_d = rst_out_q;
        if (rst_out_q) begin
            if (stretch_q >= LAST) begin
                rst_out_d = 1'b0;
                stretch_d = {SCW{1'b0}};
            end else begin
                stretch_d = stretch_q + SCW'(1);
            end
        end else begin
            stretch_d = {SCW{1'b0}};
        end
        ready_d = ~rst_out_d;
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;

    for (genvar i = 0; i < SW_W; i++) begin : g_ch
        board_input_conditioner_sw_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .hold   (rst_out_q),
            .sw_in  (sw_in[i]),
            .sw_out (sw_out[i]),
            .sw_edge(sw_edge[i])
        );
    end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Self-checking bench: directed vector table, corner-case sequences, and random stimulus
// checked against a history-window reference model.
module tb_board_input_conditioner;

    localparam int SW_W = 3;
    localparam int RSTC = 4;
    localparam int DEB  = 8;
    localparam int SYNC = 2;
    localparam int MAXC = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic [SW_W-1:0] sw_in;
    logic            rst_out;
    logic            ready;
    logic [SW_W-1:0] sw_out;
    logic [SW_W-1:0] sw_edge;

    always #5 clk = ~clk;

    board_input_conditioner #(
        .SW_W(SW_W), .RST_CYCLES(RSTC), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in),
        .rst_out(rst_out), .ready(ready), .sw_out(sw_out), .sw_edge(sw_edge)
    );

    typedef struct {
        logic            r;
        logic [SW_W-1:0] s;
        logic            ro;
        logic            rdy;
        logic [SW_W-1:0] o;
        logic [SW_W-1:0] e;
    } vec_t;

    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;
    logic [SW_W-1:0] sw_h [MAXC];
    int              last_rst = -1000;
    logic [SW_W-1:0] m_out = '0;
    logic [SW_W-1:0] m_edge;
    logic            m_ro;

    task automatic check(input string name, input logic [SW_W-1:0] act, input logic [SW_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d actual=%b required=%b", name, cyc - 1, act, exp);
        end
    endtask

    // Reference: rst_out is 1 within RSTC edges of the last rst; an output bit takes the
    // synced value (sw_in two edges earlier) once DEB consecutive unheld samples agree on it.
    task automatic model(input int n, input logic r);
        logic v;
        logic stable;
        if (r) last_rst = n;
        m_ro   = (n - last_rst) < RSTC;
        m_edge = '0;
        if ((n - last_rst) <= RSTC) begin
            m_out = '0;
        end else if ((n - last_rst) > DEB + RSTC - 1) begin
            for (int ch = 0; ch < SW_W; ch++) begin
                v      = sw_h[n - SYNC][ch];
                stable = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (sw_h[n - k - SYNC][ch] != v) stable = 1'b0;
                if (stable && (v != m_out[ch])) begin
                    m_out[ch]  = v;
                    m_edge[ch] = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [SW_W-1:0] s);
        rst   = r;
        sw_in = s;
        @(posedge clk);
        sw_h[cyc] = s;
        model(cyc, r);
        cyc++;
        @(negedge clk);
        check("rst_out", {2'b00, rst_out}, {2'b00, m_ro});
        check("ready",   {2'b00, ready},   {2'b00, ~m_ro});
        check("sw_out",  sw_out,  m_out);
        check("sw_edge", sw_edge, m_edge);
    endtask

    vec_t tbl [17];

    initial begin
        int p;
        int at;
        int f;
        int r_edge;
        logic early;
        logic [SW_W-1:0] cur;
        logic [SW_W-1:0] val;

        for (int i = 0; i < 17; i++) begin
            tbl[i].r   = (i < 2);
            tbl[i].s   = (i >= 6) ? 3'b101 : 3'b000;
            tbl[i].ro  = (i < 5);
            tbl[i].rdy = (i >= 5);
            tbl[i].o   = (i >= 15) ? 3'b101 : 3'b000;
            tbl[i].e   = (i == 15) ? 3'b101 : 3'b000;
        end

        rst   = 1'b1;
        sw_in = '0;
        @(negedge clk);

        // Reset stretch followed by a steady 101 change (sampled first at edge 6).
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].s);
            check("tbl_rst_out", {2'b00, rst_out}, {2'b00, tbl[i].ro});
            check("tbl_ready",   {2'b00, ready},   {2'b00, tbl[i].rdy});
            check("tbl_sw_out",  sw_out,  tbl[i].o);
            check("tbl_sw_edge", sw_edge, tbl[i].e);
        end

        // Bounce on channel 0: 5 high, 1 low, then steady high.
        for (int i = 0; i < 20; i++) step(1'b0, 3'b000);
        early = 1'b0;
        for (int i = 0; i < 5; i++) begin step(1'b0, 3'b001); early |= sw_out[0]; end
        step(1'b0, 3'b000);
        early |= sw_out[0];
        check("bounce_early", {2'b00, early}, 3'b000);
        f  = cyc;
        p  = 0;
        at = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 3'b001);
            if (sw_edge[0]) begin p++; at = cyc - 1; end
        end
        check("bounce_pulses", 3'(p), 3'd1);
        check("bounce_latency", 3'(at - f), 3'(SYNC + DEB - 1));

        // rst pulse while channels 1,2 are at count 6.
        p = 0;
        for (int i = 0; i < 8; i++) begin step(1'b0, 3'b111); if (sw_edge != 3'b000) p++; end
        step(1'b1, 3'b111);
        check("midrst_sw_out",  sw_out, 3'b000);
        check("midrst_rst_out", {2'b00, rst_out}, 3'b001);
        for (int i = 0; i < RSTC; i++) begin
            step(1'b0, 3'b111);
            if (sw_edge != 3'b000) p++;
            check("midrst_stretch", {2'b00, rst_out}, (i < RSTC - 1) ? 3'b001 : 3'b000);
        end
        check("midrst_no_edge", 3'(p), 3'd0);

        // 111 held through a 2-cycle reset and the full stretch.
        step(1'b1, 3'b111);
        step(1'b1, 3'b111);
        early  = 1'b0;
        r_edge = -1;
        for (int i = 0; i < RSTC; i++) begin
            step(1'b0, 3'b111);
            if (rst_out && sw_out != 3'b000) early = 1'b1;
            if (ready && r_edge < 0) r_edge = cyc - 1;
        end
        check("held_sw_out_zero", {2'b00, early}, 3'b000);
        at  = -1;
        val = '0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 3'b111);
            if (sw_edge != 3'b000 && at < 0) begin at = cyc - 1; val = sw_edge; end
        end
        check("held_edge_at", 3'(at - r_edge), 3'(DEB));
        check("held_edge_val", val, 3'b111);
        check("held_sw_out", sw_out, 3'b111);

        // Single-cycle glitch on channel 2.
        for (int i = 0; i < 20; i++) step(1'b0, 3'b011);
        p = 0;
        step(1'b0, 3'b111);
        for (int i = 0; i < 20; i++) begin step(1'b0, 3'b011); if (sw_edge[2]) p++; end
        check("glitch_edges", 3'(p), 3'd0);
        check("glitch_sw_out", sw_out, 3'b011);

        // Random bouncing switches with occasional resets.
        cur = 3'b011;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(39, 0) == 0) cur = 3'($urandom_range(7, 0));
            if ($urandom_range(5, 0) == 0)
                step($urandom_range(299, 0) == 0, 3'($urandom_range(7, 0)));
            else
                step($urandom_range(299, 0) == 0, cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
